// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed BCD adder controller (optional BCD_SUB_EN adds a sub port).
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int W = 4 * DIGITS;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [W-1:0]       opa;
  logic [W-1:0]       opb;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               sub_q;

  logic [IDX_W+1:0]   bit_idx;
  logic [3:0]         da;
  logic [3:0]         db_raw;
  logic [3:0]         db;
  logic [4:0]         raw;
  logic [3:0]         digit;
  logic               carry_nxt;
  logic               digit_bad;

  // opb keeps the original b digits so the err check sees them; the
  // nine's complement for subtraction is applied per digit on the fly.
  always_comb begin
    bit_idx   = {idx, 2'b00};
    da        = opa[bit_idx +: 4];
    db_raw    = opb[bit_idx +: 4];
    db        = sub_q ? (4'd9 - db_raw) : db_raw;
    raw       = {1'b0, da} + {1'b0, db} + {4'b0000, carry};
    digit     = raw[3:0];
    carry_nxt = 1'b0;
    if (raw > 5'd9) begin
      digit     = raw[3:0] + 4'd6;
      carry_nxt = 1'b1;
    end
    digit_bad = (da > 4'd9) | (db_raw > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      opa   <= '0;
      opb   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            idx   <= '0;
            sum   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
`ifdef BCD_SUB_EN
            sub_q <= sub;
            carry <= sub ? 1'b1 : cin;
`else
            sub_q <= 1'b0;
            carry <= cin;
`endif
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[bit_idx +: 4] <= digit;
          carry             <= carry_nxt;
          err               <= err | digit_bad;
          if (idx == LAST) begin
            cout  <= carry_nxt;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
